pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle RV32I core, directly downstream of the branch comparator.
- Consumes its BrTaken flag together with the decoder's jump controls, and holds the architectural PC.
- Each cycle it selects the next PC: sequential, branch/JAL target, or JALR target.
- Also provides a misaligned-target fault state machine with trap redirect, and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a fault is acknowledged.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  holds PC and counter when high (RUN state only).
- BrTaken  in  1  branch-taken flag from the branch comparator.
- Jump  in  1  JAL/JALR decode.
- Jalr  in  1  with Jump high, selects the rs1-relative target.
- imm  in  32  sign-extended immediate (B/J/I type) from decode.
- rs1  in  32  register-file rs1 read data.
- trap_ack  in  1  fault acknowledge from trap logic.
- pc  out  32  current PC, registered.
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32.
- pc_valid  out  1  high when pc is a fetchable instruction address.
- misalign_fault  out  1  registered; high while in FAULT.
- bad_target  out  32  registered; offending target address.
- instret  out  64  retired-instruction count.

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc=RESET_PC, state=BOOT, pc_valid=0, misalign_fault=0, bad_target=0, instret=0.
  - Deassertion is assumed synchronous to clk.
- States: BOOT, RUN, FAULT.
- BOOT:
  - Lasts exactly one cycle after reset release; pc unchanged, pc_valid=0.
  - Next state is RUN unconditionally; all other inputs are ignored.
- RUN, pc_valid=1:
  - br_tgt = pc + imm.
  - jr_tgt = (rs1 + imm) with bit 0 forced to 0.
  - All adds are 32-bit, modulo 2^32, carries dropped.
  - Target: Jump&Jalr selects jr_tgt; otherwise br_tgt.
  - redirect = Jump | BrTaken. Jalr without Jump is ignored.
  - If Jump&Jalr and BrTaken are both high, jr_tgt wins.
  - stall=1: pc, state and instret all hold. Redirect and fault detection are suppressed.
  - stall=0, redirect=0: pc <= pc+4, instret += 1. At pc=FFFF_FFFC, pc wraps to 0000_0000.
  - stall=0, redirect=1, target[1:0]==0: pc <= target, instret += 1.
  - stall=0, redirect=1, target[1:0]!=0:
    - Next state is FAULT; pc holds; instret does not increment.
    - bad_target <= target; misalign_fault <= 1.
- FAULT:
  - pc_valid=0, misalign_fault=1, pc holds at the faulting instruction.
  - stall, BrTaken, Jump are ignored.
  - trap_ack=1: pc <= TRAP_VEC, misalign_fault <= 0, next state RUN (pc_valid=1 next cycle).
  - bad_target retains its value until the next fault.
  - trap_ack in BOOT or RUN has no effect.
- Latency: every state and pc update is visible one clock after the sampling edge; pc_plus4 tracks pc combinationally.
- instret: 64-bit wrapping counter.
- Reset mid-operation (any state, including FAULT): immediately returns all state to reset values.

Test Plan:
- Reset sequence: assert rst with RESET_PC=0 -> pc=0, pc_valid=0. Release, 1 cycle BOOT, then pc_valid=1. Three free cycles -> pc 0,4,8,C; instret=3.
- Branch vs stall: at pc=0x40, BrTaken=1, imm=0xFFFF_FFF0 -> pc=0x30. Repeat with stall=1 -> pc stays 0x40, instret unchanged.
- JALR priority and bit-0 clear: pc=0x100, Jump=1, Jalr=1, BrTaken=1, rs1=0x2001, imm=4 -> pc=0x2004. Jalr=1 with Jump=0, BrTaken=0 -> pc=0x104.
- Misaligned fault: pc=0x200, BrTaken=1, imm=6 -> FAULT, misalign_fault=1, bad_target=0x206, pc=0x200, pc_valid=0.
  - Hold 3 cycles with stall toggling -> no change.
  - trap_ack=1 -> pc=0x100, fault cleared, pc_valid=1.
- Wrap: pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000, pc_plus4=0x4.
- Async reset in FAULT: assert rst mid-cycle -> outputs take reset values before the next edge; bad_target=0, instret=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter stage of the single-cycle RV32I core.
// Holds the architectural PC and picks the next one each cycle: sequential,
// branch/JAL target (pc + imm) or JALR target ((rs1 + imm) & ~1). A redirect
// to a target that is not word-aligned parks the unit in a fault state until
// the trap logic acknowledges it, after which fetch resumes at TRAP_VEC.
// Also keeps a 64-bit retired-instruction counter.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   stall          holds pc and instret while running
//   BrTaken        branch-taken flag from the branch comparator
//   Jump           JAL/JALR decode
//   Jalr           with Jump, selects the rs1-relative target
//   imm            sign-extended immediate from decode
//   rs1            register-file rs1 read data
//   trap_ack       fault acknowledge from trap logic
//   pc             current PC (registered)
//   pc_plus4       pc + 4 (combinational)
//   pc_valid       pc is a fetchable instruction address
//   misalign_fault high while a misaligned-target fault is pending
//   bad_target     offending target of the most recent fault
//   instret        retired-instruction count
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        BrTaken,
   input  logic        Jump,
   input  logic        Jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        trap_ack,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_valid,
   output logic        misalign_fault,
   output logic [31:0] bad_target,
   output logic [63:0] instret
);

   localparam logic [1:0] StBoot  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StFault = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] bad_q, bad_d;
   logic        fault_q, fault_d;
   logic [63:0] instret_q, instret_d;

   logic [31:0] br_tgt;
   logic [31:0] jr_sum;
   logic [31:0] jr_tgt;
   logic [31:0] target;
   logic        redirect;

   assign br_tgt   = pc_q + imm;
   assign jr_sum   = rs1 + imm;
   assign jr_tgt   = {jr_sum[31:1], 1'b0};
   // Jalr alone (without Jump) has no effect; Jump&Jalr overrides BrTaken.
   assign target   = (Jump && Jalr) ? jr_tgt : br_tgt;
   assign redirect = Jump | BrTaken;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      bad_d     = bad_q;
      fault_d   = fault_q;
      instret_d = instret_q;
      case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (!stall) begin
               if (redirect && (target[1:0] != 2'b00)) begin
                  // pc stays on the faulting instruction; it does not retire.
                  state_d = StFault;
                  bad_d   = target;
                  fault_d = 1'b1;
               end else begin
                  pc_d      = redirect ? target : pc_plus4;
                  instret_d = instret_q + 64'd1;
               end
            end
         end
         StFault: begin
            if (trap_ack) begin
               pc_d    = TRAP_VEC;
               fault_d = 1'b0;
               state_d = StRun;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StBoot;
         pc_q      <= RESET_PC;
         bad_q     <= 32'h0;
         fault_q   <= 1'b0;
         instret_q <= 64'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         bad_q     <= bad_d;
         fault_q   <= fault_d;
         instret_q <= instret_d;
      end
   end

   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign pc_valid       = (state_q == StRun);
   assign misalign_fault = fault_q;
   assign bad_target     = bad_q;
   assign instret        = instret_q;

endmodule
